// File: rtl/sata_phy_rx_filter_pkg.sv
// Shared SATA definitions: primitive dwords, primitive codes, RX filter states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sata_phy_rx_filter_pkg;

    // K28.5 and K28.3 lead every SATA primitive in byte 0
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_3 = 8'h7C;

    // Full 32-bit primitive dwords, byte 0 in bits [7:0]
    localparam logic [31:0] PRIM_DW_ALIGN   = 32'h7B4A_4ABC;
    localparam logic [31:0] PRIM_DW_SYNC    = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_DW_CONT    = 32'h9999_AA7C;
    localparam logic [31:0] PRIM_DW_X_RDY   = 32'h5757_B57C;
    localparam logic [31:0] PRIM_DW_R_RDY   = 32'h4A4A_957C;
    localparam logic [31:0] PRIM_DW_SOF     = 32'h3737_B57C;
    localparam logic [31:0] PRIM_DW_EOF     = 32'hD5D5_B57C;
    localparam logic [31:0] PRIM_DW_HOLD    = 32'hD5D5_AA7C;
    localparam logic [31:0] PRIM_DW_HOLDA   = 32'h9595_AA7C;
    localparam logic [31:0] PRIM_DW_WTRM    = 32'h5858_B57C;
    localparam logic [31:0] PRIM_DW_R_IP    = 32'h5555_B57C;
    localparam logic [31:0] PRIM_DW_R_OK    = 32'h3535_B57C;
    localparam logic [31:0] PRIM_DW_R_ERR   = 32'h5656_B57C;
    localparam logic [31:0] PRIM_DW_DMAT    = 32'h3636_B57C;
    localparam logic [31:0] PRIM_DW_PMREQ_P = 32'h1717_B57C;
    localparam logic [31:0] PRIM_DW_PMREQ_S = 32'h7575_957C;
    localparam logic [31:0] PRIM_DW_PMACK   = 32'h9595_957C;
    localparam logic [31:0] PRIM_DW_PMNAK   = 32'hF5F5_957C;

    // Compact primitive code handed to the link layer
    typedef enum logic [4:0] {
        PRIM_NONE    = 5'd0,
        PRIM_ALIGN   = 5'd1,
        PRIM_SYNC    = 5'd2,
        PRIM_CONT    = 5'd3,
        PRIM_X_RDY   = 5'd4,
        PRIM_R_RDY   = 5'd5,
        PRIM_SOF     = 5'd6,
        PRIM_EOF     = 5'd7,
        PRIM_HOLD    = 5'd8,
        PRIM_HOLDA   = 5'd9,
        PRIM_WTRM    = 5'd10,
        PRIM_R_IP    = 5'd11,
        PRIM_R_OK    = 5'd12,
        PRIM_R_ERR   = 5'd13,
        PRIM_DMAT    = 5'd14,
        PRIM_PMREQ_P = 5'd15,
        PRIM_PMREQ_S = 5'd16,
        PRIM_PMACK   = 5'd17,
        PRIM_PMNAK   = 5'd18
    } prim_code_t;

    // RX filter alignment states
    localparam logic [1:0] ST_WAIT_LINK  = 2'd0;
    localparam logic [1:0] ST_WAIT_ALIGN = 2'd1;
    localparam logic [1:0] ST_SYNCED     = 2'd2;
    localparam logic [1:0] ST_LOST       = 2'd3;

endpackage

// File: rtl/sata_prim_decoder.sv
// Classifies one received dword as primitive (with code), data, or illegal.
// Latency: purely combinational.
// Backpressure: none; evaluates every dword presented.
module sata_prim_decoder
    import sata_phy_rx_filter_pkg::*;
(
    input  logic [31:0] dword,
    input  logic [3:0]  isk,
    output logic        is_prim,
    output prim_code_t  code,
    output logic        is_error
);

    // Only a K28.3/K28.5 in byte 0 with no other K bytes can be a primitive;
    // it must then match a known dword exactly. Any other K pattern is illegal.
    always_comb begin
        is_prim  = 1'b0;
        code     = PRIM_NONE;
        is_error = 1'b0;
        if (isk == 4'b0001 && (dword[7:0] == K28_5 || dword[7:0] == K28_3)) begin
            is_prim = 1'b1;
            case (dword)
                PRIM_DW_ALIGN:   code = PRIM_ALIGN;
                PRIM_DW_SYNC:    code = PRIM_SYNC;
                PRIM_DW_CONT:    code = PRIM_CONT;
                PRIM_DW_X_RDY:   code = PRIM_X_RDY;
                PRIM_DW_R_RDY:   code = PRIM_R_RDY;
                PRIM_DW_SOF:     code = PRIM_SOF;
                PRIM_DW_EOF:     code = PRIM_EOF;
                PRIM_DW_HOLD:    code = PRIM_HOLD;
                PRIM_DW_HOLDA:   code = PRIM_HOLDA;
                PRIM_DW_WTRM:    code = PRIM_WTRM;
                PRIM_DW_R_IP:    code = PRIM_R_IP;
                PRIM_DW_R_OK:    code = PRIM_R_OK;
                PRIM_DW_R_ERR:   code = PRIM_R_ERR;
                PRIM_DW_DMAT:    code = PRIM_DMAT;
                PRIM_DW_PMREQ_P: code = PRIM_PMREQ_P;
                PRIM_DW_PMREQ_S: code = PRIM_PMREQ_S;
                PRIM_DW_PMACK:   code = PRIM_PMACK;
                PRIM_DW_PMNAK:   code = PRIM_PMNAK;
                default: begin
                    is_prim  = 1'b0;
                    is_error = 1'b1;
                end
            endcase
        end else if (isk != 4'b0000) begin
            is_error = 1'b1;
        end
    end

endmodule

// File: rtl/sata_phy_rx_filter.sv
// Strips ALIGNs, classifies and CONT-expands the RX dword stream, tracks alignment health.
// Latency: one cycle, every output registered.
// Backpressure: none; one dword accepted per clk, dropped dwords simply produce no valid.
module sata_phy_rx_filter
    import sata_phy_rx_filter_pkg::*;
#(
    parameter int ALIGN_TIMEOUT  = 1024,
    parameter int MISALIGN_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        linkup,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_isk,
    input  logic        rx_byte_is_aligned,
    output logic [31:0] rx_dout,
    output logic        rx_data_valid,
    output logic [4:0]  rx_prim,
    output logic        rx_prim_valid,
    output logic        in_cont,
    output logic        phy_aligned,
    output logic        align_lost,
    output logic        prim_error
);

    localparam int          MIS_W     = $clog2(MISALIGN_LIMIT + 1);
    localparam logic [10:0] DW_LIMIT  = 11'(ALIGN_TIMEOUT);
    localparam logic [MIS_W-1:0] MIS_LIMIT = MIS_W'(MISALIGN_LIMIT);

    logic [1:0]       state;
    logic [10:0]      dw_cnt;
    logic [10:0]      dw_cnt_nxt;
    logic [MIS_W-1:0] mis_cnt;
    logic [MIS_W-1:0] mis_cnt_nxt;
    prim_code_t       held;

    logic       dec_is_prim;
    prim_code_t dec_code;
    logic       dec_err;
    logic       is_align;
    logic       is_cont;
    logic       loss;

    sata_prim_decoder u_dec (
        .dword    (rx_din),
        .isk      (rx_isk),
        .is_prim  (dec_is_prim),
        .code     (dec_code),
        .is_error (dec_err)
    );

    assign is_align = dec_is_prim && (dec_code == PRIM_ALIGN);
    assign is_cont  = dec_is_prim && (dec_code == PRIM_CONT);

    // Saturating health counters as they would stand after this dword
    always_comb begin
        dw_cnt_nxt  = dw_cnt;
        mis_cnt_nxt = mis_cnt;
        if (is_align) begin
            dw_cnt_nxt = '0;
        end else if (dw_cnt != '1) begin
            dw_cnt_nxt = dw_cnt + 11'd1;
        end
        if (rx_byte_is_aligned) begin
            mis_cnt_nxt = '0;
        end else if (mis_cnt != '1) begin
            mis_cnt_nxt = mis_cnt + MIS_W'(1);
        end
    end

    // Either source of loss yields the same single transition into LOST
    assign loss = (dw_cnt_nxt >= DW_LIMIT) || (mis_cnt_nxt >= MIS_LIMIT);

    // Alignment state machine plus registered forwarding of the classified dword
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_WAIT_LINK;
            dw_cnt        <= '0;
            mis_cnt       <= '0;
            held          <= PRIM_NONE;
            rx_dout       <= '0;
            rx_data_valid <= 1'b0;
            rx_prim       <= PRIM_NONE;
            rx_prim_valid <= 1'b0;
            in_cont       <= 1'b0;
            phy_aligned   <= 1'b0;
            align_lost    <= 1'b0;
            prim_error    <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            rx_prim_valid <= 1'b0;
            align_lost    <= 1'b0;
            prim_error    <= 1'b0;
            if (!linkup) begin
                // Link drop is not an alignment loss: quiet reset of the pipeline
                state       <= ST_WAIT_LINK;
                dw_cnt      <= '0;
                mis_cnt     <= '0;
                held        <= PRIM_NONE;
                in_cont     <= 1'b0;
                phy_aligned <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_LINK: begin
                        state <= ST_WAIT_ALIGN;
                    end
                    ST_WAIT_ALIGN: begin
                        if (is_align && rx_byte_is_aligned) begin
                            state       <= ST_SYNCED;
                            phy_aligned <= 1'b1;
                            dw_cnt      <= '0;
                            mis_cnt     <= '0;
                        end
                    end
                    ST_SYNCED: begin
                        dw_cnt  <= dw_cnt_nxt;
                        mis_cnt <= mis_cnt_nxt;
                        if (dec_err) begin
                            prim_error <= 1'b1;
                        end else if (is_cont) begin
                            // A CONT only means something if a primitive precedes it
                            if (!in_cont) begin
                                if (held == PRIM_NONE) begin
                                    prim_error <= 1'b1;
                                end else begin
                                    in_cont <= 1'b1;
                                end
                            end
                        end else if (dec_is_prim) begin
                            if (!is_align) begin
                                rx_prim       <= dec_code;
                                rx_prim_valid <= 1'b1;
                                held          <= dec_code;
                                in_cont       <= 1'b0;
                            end
                        end else if (in_cont) begin
                            // Scrambled junk stands in for repeats of the held primitive
                            rx_prim       <= held;
                            rx_prim_valid <= 1'b1;
                        end else begin
                            rx_dout       <= rx_din;
                            rx_data_valid <= 1'b1;
                        end
                        if (loss) begin
                            state       <= ST_LOST;
                            align_lost  <= 1'b1;
                            phy_aligned <= 1'b0;
                            in_cont     <= 1'b0;
                            held        <= PRIM_NONE;
                        end
                    end
                    default: begin
                        state   <= ST_WAIT_ALIGN;
                        dw_cnt  <= '0;
                        mis_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sata_phy_rx_filter.sv
// Randomized and directed checks of sata_phy_rx_filter against a stream-level reference model.
// Latency: model predicts outputs one cycle after each driven dword.
// Backpressure: none; one dword driven per clock.
module tb_sata_phy_rx_filter;

    localparam int C_ALIGN = 1;
    localparam int C_SYNC  = 2;
    localparam int C_CONT  = 3;
    localparam int C_HOLD  = 8;
    localparam int C_HOLDA = 9;

    localparam int P_DOWN = 0;
    localparam int P_HUNT = 1;
    localparam int P_SYNC = 2;
    localparam int P_LOST = 3;

    logic        clk;
    logic        rst;
    logic        linkup;
    logic [31:0] rx_din;
    logic [3:0]  rx_isk;
    logic        rx_byte_is_aligned;
    logic [31:0] rx_dout;
    logic        rx_data_valid;
    logic [4:0]  rx_prim;
    logic        rx_prim_valid;
    logic        in_cont;
    logic        phy_aligned;
    logic        align_lost;
    logic        prim_error;

    int n_chk;
    int n_fail;

    // model state
    int          m_phase;
    int          m_held;
    int          m_since;
    int          m_low;
    logic        m_aligned;
    logic        m_cont;
    logic        e_dv;
    logic        e_pv;
    logic        e_err;
    logic        e_lost;
    logic [4:0]  e_prim;
    logic [31:0] e_dout;

    // observation tallies
    int o_dv;
    int o_lost;
    int o_err;
    int o_notal;
    int o_align_fwd;
    int o_hits [32];

    sata_phy_rx_filter dut (
        .clk                (clk),
        .rst                (rst),
        .linkup             (linkup),
        .rx_din             (rx_din),
        .rx_isk             (rx_isk),
        .rx_byte_is_aligned (rx_byte_is_aligned),
        .rx_dout            (rx_dout),
        .rx_data_valid      (rx_data_valid),
        .rx_prim            (rx_prim),
        .rx_prim_valid      (rx_prim_valid),
        .in_cont            (in_cont),
        .phy_aligned        (phy_aligned),
        .align_lost         (align_lost),
        .prim_error         (prim_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dw_of(input int code);
        case (code)
            1:  return 32'h7B4A_4ABC;
            2:  return 32'hB5B5_957C;
            3:  return 32'h9999_AA7C;
            4:  return 32'h5757_B57C;
            5:  return 32'h4A4A_957C;
            6:  return 32'h3737_B57C;
            7:  return 32'hD5D5_B57C;
            8:  return 32'hD5D5_AA7C;
            9:  return 32'h9595_AA7C;
            10: return 32'h5858_B57C;
            11: return 32'h5555_B57C;
            12: return 32'h3535_B57C;
            13: return 32'h5656_B57C;
            14: return 32'h3636_B57C;
            15: return 32'h1717_B57C;
            16: return 32'h7575_957C;
            17: return 32'h9595_957C;
            18: return 32'hF5F5_957C;
            default: return 32'h0;
        endcase
    endfunction

    // -1 illegal, 0 data, otherwise primitive code
    function automatic int classify(input logic [31:0] d, input logic [3:0] k);
        if (k == 4'b0000) return 0;
        if (k == 4'b0001) begin
            for (int c = 1; c <= 18; c++) begin
                if (dw_of(c) == d) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_step(input logic [31:0] d, input logic [3:0] k, input logic a, input logic l);
        int c;
        e_dv = 1'b0;
        e_pv = 1'b0;
        e_err = 1'b0;
        e_lost = 1'b0;
        if (!l) begin
            m_phase = P_DOWN;
            m_aligned = 1'b0;
            m_cont = 1'b0;
            m_held = 0;
            m_since = 0;
            m_low = 0;
        end else if (m_phase == P_DOWN || m_phase == P_LOST) begin
            m_phase = P_HUNT;
        end else if (m_phase == P_HUNT) begin
            if (a && classify(d, k) == C_ALIGN) begin
                m_phase = P_SYNC;
                m_aligned = 1'b1;
                m_since = 0;
                m_low = 0;
            end
        end else begin
            c = classify(d, k);
            if (c < 0) begin
                e_err = 1'b1;
            end else if (c == C_CONT) begin
                if (!m_cont && m_held == 0) e_err = 1'b1;
                else if (!m_cont) m_cont = 1'b1;
            end else if (c > 0 && c != C_ALIGN) begin
                e_pv = 1'b1;
                e_prim = 5'(c);
                m_held = c;
                m_cont = 1'b0;
            end else if (c == 0 && m_cont) begin
                e_pv = 1'b1;
                e_prim = 5'(m_held);
            end else if (c == 0) begin
                e_dv = 1'b1;
                e_dout = d;
            end
            m_since = (c == C_ALIGN) ? 0 : m_since + 1;
            m_low = a ? 0 : m_low + 1;
            if (m_since >= 1024 || m_low >= 4) begin
                e_lost = 1'b1;
                m_phase = P_LOST;
                m_aligned = 1'b0;
                m_cont = 1'b0;
                m_held = 0;
            end
        end
    endtask

    task automatic clear_obs();
        o_dv = 0;
        o_lost = 0;
        o_err = 0;
        o_notal = 0;
        foreach (o_hits[i]) o_hits[i] = 0;
    endtask

    // Drive one dword, advance one clock, compare every output with the model
    task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic a, input logic l);
        rx_din = d;
        rx_isk = k;
        rx_byte_is_aligned = a;
        linkup = l;
        model_step(d, k, a, l);
        @(posedge clk);
        #1;
        chk("data_valid", 32'(rx_data_valid), 32'(e_dv));
        chk("prim_valid", 32'(rx_prim_valid), 32'(e_pv));
        if (e_pv) chk("prim_code", 32'(rx_prim), 32'(e_prim));
        if (e_dv) chk("dout", rx_dout, e_dout);
        chk("prim_error", 32'(prim_error), 32'(e_err));
        chk("align_lost", 32'(align_lost), 32'(e_lost));
        chk("in_cont", 32'(in_cont), 32'(m_cont));
        chk("phy_aligned", 32'(phy_aligned), 32'(m_aligned));
        chk("valid_exclusive", 32'(rx_data_valid & rx_prim_valid), 32'(0));
        if (rx_data_valid) o_dv++;
        if (align_lost) o_lost++;
        if (prim_error) o_err++;
        if (!phy_aligned) o_notal++;
        if (rx_prim_valid) o_hits[rx_prim]++;
        if (rx_prim_valid && rx_prim == 5'(C_ALIGN)) o_align_fwd++;
    endtask

    task automatic cp(input int code);
        cyc(dw_of(code), 4'b0001, 1'b1, 1'b1);
    endtask

    task automatic cd(input logic [31:0] d);
        cyc(d, 4'b0000, 1'b1, 1'b1);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        o_align_fwd = 0;
        clear_obs();
        m_phase = P_DOWN;
        m_held = 0;
        m_since = 0;
        m_low = 0;
        m_aligned = 1'b0;
        m_cont = 1'b0;
        e_prim = '0;
        e_dout = '0;
        rst = 1'b1;
        linkup = 1'b0;
        rx_din = '0;
        rx_isk = '0;
        rx_byte_is_aligned = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_valid", 32'(rx_data_valid), 32'(0));
        chk("rst_prim_valid", 32'(rx_prim_valid), 32'(0));
        chk("rst_prim", 32'(rx_prim), 32'(0));
        chk("rst_dout", rx_dout, 32'(0));
        chk("rst_in_cont", 32'(in_cont), 32'(0));
        chk("rst_aligned", 32'(phy_aligned), 32'(0));
        chk("rst_lost", 32'(align_lost), 32'(0));
        chk("rst_error", 32'(prim_error), 32'(0));
        rst = 1'b0;

        // bring-up: link, ALIGN, three SYNCs, one data dword
        cd(32'h0);
        cp(C_ALIGN);
        chk("aligned_after_align", 32'(phy_aligned), 32'(1));
        clear_obs();
        repeat (3) cp(C_SYNC);
        chk("sync_count", o_hits[C_SYNC], 3);
        cd(32'h1234_5678);
        chk("first_data_valid", 32'(rx_data_valid), 32'(1));
        chk("first_data", rx_dout, 32'h1234_5678);

        // ALIGN pairs interleaved with 256 data dwords
        clear_obs();
        for (int i = 0; i < 256; i++) begin
            if (i % 32 == 0) begin
                cp(C_ALIGN);
                cp(C_ALIGN);
            end
            cd($urandom);
        end
        chk("data_256", o_dv, 256);
        chk("aligned_held", o_notal, 0);

        // CONT run: HOLD, CONT, 5 junk, ALIGN, 2 junk, HOLDA
        clear_obs();
        cp(C_HOLD);
        cp(C_CONT);
        chk("cont_entered", 32'(in_cont), 32'(1));
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                cp(C_ALIGN);
                chk("cont_align_quiet", 32'(rx_prim_valid), 32'(0));
            end else begin
                cd($urandom);
                chk("cont_junk_hold", 32'(rx_prim_valid && rx_prim == 5'(C_HOLD)), 32'(1));
            end
            chk("cont_active", 32'(in_cont), 32'(1));
        end
        cp(C_HOLDA);
        chk("holda_fwd", 32'(rx_prim_valid && rx_prim == 5'(C_HOLDA)), 32'(1));
        chk("cont_ended", 32'(in_cont), 32'(0));
        chk("hold_cycles", o_hits[C_HOLD], 8);
        chk("cont_no_data", o_dv, 0);

        // ALIGN timeout after 1024 non-ALIGN dwords
        cp(C_ALIGN);
        clear_obs();
        repeat (1023) cd($urandom);
        chk("no_early_timeout", o_lost, 0);
        cd($urandom);
        chk("timeout_pulse", 32'(align_lost), 32'(1));
        chk("timeout_unaligned", 32'(phy_aligned), 32'(0));
        cd($urandom);
        cd($urandom);
        chk("timeout_once", o_lost, 1);
        chk("hunt_no_data", 32'(rx_data_valid), 32'(0));
        cp(C_ALIGN);
        chk("timeout_resync", 32'(phy_aligned), 32'(1));

        // comma misalignment: 3 low cycles tolerated, 4 cause loss
        clear_obs();
        repeat (3) cyc($urandom, 4'b0000, 1'b0, 1'b1);
        repeat (2) cd($urandom);
        chk("mis3_no_loss", o_lost, 0);
        chk("mis3_aligned", 32'(phy_aligned), 32'(1));
        repeat (4) cyc($urandom, 4'b0000, 1'b0, 1'b1);
        chk("mis4_loss", o_lost, 1);
        chk("mis4_unaligned", 32'(phy_aligned), 32'(0));
        cd($urandom);
        cp(C_ALIGN);
        chk("mis_resync", 32'(phy_aligned), 32'(1));

        // errors: CONT with nothing held, bad K pattern, unknown K28 dword
        clear_obs();
        cp(C_CONT);
        chk("cont_nohold_err", 32'(prim_error), 32'(1));
        chk("cont_nohold_quiet", 32'(rx_prim_valid | rx_data_valid | in_cont), 32'(0));
        cyc(32'h0000_BCBC, 4'b0010, 1'b1, 1'b1);
        chk("bad_isk_err", 32'(prim_error), 32'(1));
        chk("bad_isk_quiet", 32'(rx_prim_valid | rx_data_valid), 32'(0));
        cyc(32'h1234_56BC, 4'b0001, 1'b1, 1'b1);
        chk("unknown_k28_err", 32'(prim_error), 32'(1));
        chk("err_pulses", o_err, 3);

        // link drop in the middle of a CONT run
        cp(C_HOLD);
        cp(C_CONT);
        cd($urandom);
        clear_obs();
        cyc($urandom, 4'b0000, 1'b1, 1'b0);
        chk("drop_in_cont", 32'(in_cont), 32'(0));
        chk("drop_aligned", 32'(phy_aligned), 32'(0));
        chk("drop_no_lost", o_lost, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [31:0] d;
            logic [3:0]  k;
            r = int'($urandom_range(0, 15));
            if (r < 2) begin
                d = dw_of(C_ALIGN);
                k = 4'b0001;
            end else if (r < 7) begin
                d = dw_of(int'($urandom_range(2, 18)));
                k = 4'b0001;
            end else if (r == 7) begin
                if ($urandom_range(0, 1) == 0) begin
                    d = $urandom;
                    k = 4'($urandom_range(2, 15));
                end else begin
                    d = {24'($urandom), 8'hBC};
                    k = 4'b0001;
                end
            end else begin
                d = $urandom;
                k = 4'b0000;
            end
            cyc(d, k, $urandom_range(0, 19) != 0, $urandom_range(0, 999) != 0);
        end

        chk("align_never_forwarded", o_align_fwd, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
